// File: rtl/uart_transceiver.sv
// Full-duplex 8-bit UART: 16x oversampled receiver, cycle-counted transmitter.
// Define UART_PARITY_EN for 11-bit frames with an even parity bit and parity_err checking.
module uart_transceiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int DIV     = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC = 16 * DIV;
  localparam int DW      = $clog2(DIV);
  localparam int CW      = $clog2(BIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t        rx_state, rx_state_next, tx_state, tx_state_next;
  logic [DW-1:0] div_cnt;
  logic          rx_tick, rx_meta, rx_sync, rx_bit_end, rx_stop_done, parity_bad;
  logic [3:0]    rx_tick_cnt;
  logic [2:0]    rx_bit_cnt, tx_bit_cnt, tx_idx;
  logic [7:0]    rx_shift, tx_byte;
  logic [CW-1:0] tx_cyc;
  logic          tx_bit_end, tx_line_next;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter how the always blocks are ordered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= S_IDLE;
      tx_state <= S_IDLE;
    end else begin
      div_cnt  <= rx_tick ? '0 : div_cnt + DW'(1);
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_next;
      tx_state <= tx_state_next;
    end
  end

  assign rx_tick    = (div_cnt == DW'(DIV - 1));
  assign rx_bit_end = rx_tick && (rx_tick_cnt == 4'd15);

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    rx_state_next = rx_state;
    rx_stop_done  = 1'b0;
    unique case (rx_state)
      S_IDLE:   if (!rx_sync) rx_state_next = S_START;
      S_START:  if (rx_tick && rx_tick_cnt == 4'd7) rx_state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:   if (rx_bit_end && rx_bit_cnt == 3'd7) rx_state_next = AFTER_DATA;
`ifdef UART_PARITY_EN
      S_PARITY: if (rx_bit_end) rx_state_next = S_STOP;
`endif
      S_STOP: begin
        if (rx_bit_end) begin
          rx_state_next = S_IDLE;
          rx_stop_done  = 1'b1;
        end
      end
      default:  rx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
    end else begin
      // Any state change restarts the count; inside DATA the 4-bit count wraps 15->0 per bit.
      if (rx_state == S_IDLE || rx_state_next != rx_state) rx_tick_cnt <= '0;
      else if (rx_tick) rx_tick_cnt <= rx_tick_cnt + 4'd1;
      if (rx_state != S_DATA) rx_bit_cnt <= '0;
      else if (rx_bit_end) rx_bit_cnt <= rx_bit_cnt + 3'd1;
      if (rx_state == S_DATA && rx_bit_end) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_par_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_state == S_PARITY && rx_bit_end) rx_par_bit <= rx_sync;
      parity_err <= rx_stop_done && rx_sync && parity_bad;
    end
  end

  assign parity_bad = (^rx_shift) != rx_par_bit;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= rx_stop_done && !rx_sync;
      if (rx_stop_done && rx_sync && !parity_bad) begin
        // An ack landing with the delivery frees the slot, so overrun is left untouched.
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

  assign tx_bit_end = (tx_cyc == CW'(BIT_CYC - 1));
  assign tx_busy    = (tx_state != S_IDLE);

  always_comb begin
    tx_state_next = tx_state;
    tx_idx        = '0;
    tx_line_next  = 1'b1;
    unique case (tx_state)
      S_IDLE:   if (tx_start) tx_state_next = S_START;
      S_START:  if (tx_bit_end) tx_state_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_bit_cnt == 3'd7) tx_state_next = AFTER_DATA;
`ifdef UART_PARITY_EN
      S_PARITY: if (tx_bit_end) tx_state_next = S_STOP;
`endif
      S_STOP:   if (tx_bit_end) tx_state_next = S_IDLE;
      default:  tx_state_next = S_IDLE;
    endcase
    // tx is registered, so drive the level of the bit that the next state will be sending.
    if (tx_state == S_DATA) tx_idx = tx_bit_cnt + 3'(tx_bit_end);
    case (tx_state_next)
      S_START:  tx_line_next = 1'b0;
      S_DATA:   tx_line_next = tx_byte[tx_idx];
`ifdef UART_PARITY_EN
      S_PARITY: tx_line_next = ^tx_byte;
`endif
      default:  tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx         <= 1'b1;
      tx_cyc     <= '0;
      tx_bit_cnt <= '0;
      tx_byte    <= '0;
    end else begin
      tx <= tx_line_next;
      if (tx_state == S_IDLE || tx_bit_end) tx_cyc <= '0;
      else tx_cyc <= tx_cyc + CW'(1);
      if (tx_state != S_DATA) tx_bit_cnt <= '0;
      else if (tx_bit_end) tx_bit_cnt <= tx_bit_cnt + 3'd1;
      if (tx_state == S_IDLE && tx_start) tx_byte <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: table-driven RX vectors, random TX/RX
// against a frame-level reference model, plus collision, glitch, reset and parity corners.
`timescale 1ns/1ps
module tb_uart_transceiver;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC  = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // rx_ticks from the first tick after START entry up to the stop-bit sample
  localparam int STOP_TICKS = 8 + 16 * (NBITS - 1);

  logic       clk = 1'b0, reset = 1'b0, rx = 1'b1, rx_ack = 1'b0, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, rx_valid, rx_overrun, frame_err, parity_err;
  logic [7:0] rx_data;

  int checks = 0, errors = 0;
  int cyc;
  int ferr_seen = 0, perr_seen = 0;

  // Reference model of the receive-side register state
  logic       m_valid = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  typedef struct {
    bit         ack_first;
    logic [7:0] data;
    bit         bad_stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs[6];

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; modulo DIV this is the free-running oversample counter.
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (parity_err) perr_seen++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit bad);
    if (bad) return;
    if (!m_valid) begin
      m_data  = d;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  // Drive one frame on rx; optional bad stop (low for the first 100 cycles of the
  // stop bit), flipped parity, alignment to an oversample wrap, and an rx_ack at a cycle offset.
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit flip,
                            input bit align, input int ack_at);
    if (align) while (cyc % DIV != 0) step();
    for (int i = 0; i < NBITS * BIT_CYC; i++) begin
      int   bi;
      logic b;
      bi = i / BIT_CYC;
      b  = frame_bit(d, bi);
      if (flip && NBITS == 11 && bi == 9) b = ~b;
      if (bad_stop && bi == NBITS - 1 && (i % BIT_CYC) < 100) b = 1'b0;
      rx     = b;
      rx_ack = (i == ack_at);
      step();
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
    step(100);
  endtask

  task automatic check_rx_model(input string tag, input int ferr0, input int ferr_exp);
    check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, "_data"}, 32'(rx_data), 32'(m_data));
    check({tag, "_ovr"}, 32'(rx_overrun), 32'(m_ovr));
    check({tag, "_ferr"}, 32'(ferr_seen - ferr0), 32'(ferr_exp));
  endtask

  // Send a byte and verify every cycle of the frame; optionally retry tx_start mid-frame.
  task automatic tx_frame(input logic [7:0] d, input bit poke);
    int bad;
    for (int w = 0; w < 2 * NBITS * BIT_CYC && tx_busy; w++) step();
    check("tx_idle_before_start", 32'(tx_busy), 32'd0);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check($sformatf("tx_%02h_start_low", d), 32'(tx), 32'd0);
    check($sformatf("tx_%02h_busy_rise", d), 32'(tx_busy), 32'd1);
    for (int b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (tx !== frame_bit(d, b) || tx_busy !== 1'b1) bad++;
        if (poke && b == 4 && c == 7) begin
          tx_data  = ~d;
          tx_start = 1'b1;
        end else begin
          tx_start = 1'b0;
        end
        step();
      end
      check($sformatf("tx_%02h_bit%0d_bad_cycles", d, b), 32'(bad), 32'd0);
    end
    check($sformatf("tx_%02h_busy_fall", d), 32'(tx_busy), 32'd0);
    check($sformatf("tx_%02h_line_idle", d), 32'(tx), 32'd1);
  endtask

  initial begin
    int f0, p0;
    logic [7:0] d;
    bit ackf, bad;

    vecs[0] = '{0, 8'h3C, 0, 1'b1, 8'h3C, 1'b0, 0};
    vecs[1] = '{1, 8'h11, 0, 1'b1, 8'h11, 1'b0, 0};
    vecs[2] = '{0, 8'h22, 0, 1'b1, 8'h11, 1'b1, 0};
    vecs[3] = '{1, 8'h5A, 1, 1'b0, 8'h11, 1'b0, 1};
    vecs[4] = '{0, 8'h81, 0, 1'b1, 8'h81, 1'b0, 0};
    vecs[5] = '{1, 8'hFF, 0, 1'b1, 8'hFF, 1'b0, 0};

    step(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b1;
    step(5);

    // TX: fixed byte with an ignored mid-frame request, then random back-to-back frames
    tx_frame(8'hA5, 1'b1);
    for (int k = 0; k < 4; k++) tx_frame(8'($urandom), 1'b0);
`ifdef UART_PARITY_EN
    tx_frame(8'h07, 1'b0);
`endif

    // Reset mid-TX (with a partial RX frame in flight) aborts both paths at once
    f0 = ferr_seen;
    rx = 1'b0;
    tx_data  = 8'h00;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    step(300);
    check("midtx_busy_before_reset", 32'(tx_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midtx_reset_tx", 32'(tx), 32'd1);
    check("midtx_reset_busy", 32'(tx_busy), 32'd0);
    step(2);
    rx = 1'b1;
    step(1);
    reset = 1'b1;
    step(NBITS * BIT_CYC + 200);
    check("midrx_reset_no_byte", 32'(rx_valid), 32'd0);
    check("midrx_reset_no_ferr", 32'(ferr_seen - f0), 32'd0);
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;

    // RX: table-driven sequence (ack, overrun, bad stop)
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].ack_first) begin
        ack_pulse();
        check($sformatf("vec%0d_ack_clears_valid", k), 32'(rx_valid), 32'd0);
        check($sformatf("vec%0d_ack_clears_ovr", k), 32'(rx_overrun), 32'd0);
        model_ack();
      end
      f0 = ferr_seen;
      send_frame(vecs[k].data, vecs[k].bad_stop, 1'b0, 1'b0, -1);
      model_frame(vecs[k].data, vecs[k].bad_stop);
      check($sformatf("vec%0d_valid", k), 32'(rx_valid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_ovr", k), 32'(rx_overrun), 32'(vecs[k].exp_ovr));
      check($sformatf("vec%0d_ferr_pulses", k), 32'(ferr_seen - f0), 32'(vecs[k].exp_ferr));
    end

    // RX: random bytes, random acks (also while empty), occasional bad stop bit
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      ackf = ($urandom_range(0, 1) == 1);
      bad  = ($urandom_range(0, 3) == 0);
      if (ackf) begin
        ack_pulse();
        model_ack();
      end
      f0 = ferr_seen;
      send_frame(d, bad, 1'b0, 1'b0, -1);
      model_frame(d, bad);
      check_rx_model($sformatf("rand%0d", k), f0, bad ? 1 : 0);
    end

    // Short low glitch: rejected at the mid-start-bit sample
    f0 = ferr_seen;
    p0 = perr_seen;
    rx = 1'b0;
    step(40);
    rx = 1'b1;
    step(300);
    check_rx_model("glitch", f0, 0);
    check("glitch_perr", 32'(perr_seen - p0), 32'd0);

    // Ack landing in the exact delivery cycle, first with overrun clear, then set
    ack_pulse();
    model_ack();
    send_frame(8'h44, 1'b0, 1'b0, 1'b0, -1);
    model_frame(8'h44, 1'b0);
    f0 = ferr_seen;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, DIV * STOP_TICKS - 1);
    m_data = 8'h99;
    check_rx_model("collide_clr", f0, 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    model_frame(8'h55, 1'b0);
    check("collide_pre_ovr", 32'(rx_overrun), 32'd1);
    f0 = ferr_seen;
    send_frame(8'h66, 1'b0, 1'b0, 1'b1, DIV * STOP_TICKS - 1);
    m_data = 8'h66;
    check_rx_model("collide_ovr_kept", f0, 0);
    ack_pulse();
    model_ack();
    check("collide_final_ack_valid", 32'(rx_valid), 32'd0);
    check("collide_final_ack_ovr", 32'(rx_overrun), 32'd0);

`ifdef UART_PARITY_EN
    // Flipped parity bit: byte discarded, one parity_err pulse, no frame_err
    f0 = ferr_seen;
    p0 = perr_seen;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    check_rx_model("par_flip", f0, 0);
    check("par_flip_perr_pulses", 32'(perr_seen - p0), 32'd1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1);
    model_frame(8'h5A, 1'b0);
    check_rx_model("par_good", f0, 0);
`endif
    check("parity_err_total", 32'(perr_seen), (NBITS == 11) ? 32'd1 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex 8-bit UART serial port for the single-cycle MIPS board. It sits directly beside the memory-mapped peripheral block. It turns the board's serial RX pin into received bytes that the peripheral can read, and it turns bytes written by the peripheral into a serial TX frame. A byte-level valid/ack handshake on receive and a start/busy handshake on transmit let the peripheral register file poll these flags or raise an interrupt from them.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate. The oversample divider is DIV = CLK_FREQ / (BAUD*16), rounded down; DIV must be at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line in; asynchronous to clk; idles high.
- tx  output  1  serial line out; idles high.
- tx_data  input  8  byte to transmit; sampled when tx_start is accepted.
- tx_start  input  1  one-cycle request to send tx_data.
- tx_busy  output  1  a frame is in progress.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ack  input  1  one-cycle pulse that consumes rx_data.
- rx_overrun  output  1  sticky flag: a byte was lost while rx_valid was high.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on a parity mismatch. Only active with UART_PARITY_EN.

## Operation
- **Reset values:** tx=1, tx_busy=0, rx_data=0, rx_valid=0, rx_overrun=0, frame_err=0, parity_err=0. All counters are 0, both FSMs are in IDLE, and the rx synchronizer flops are 1. Asserting reset mid-frame aborts the frame immediately; no partial byte is delivered.
- **Tick generator:**
  - Free-running counter 0..DIV-1.
  - rx_tick pulses for one cycle when the counter equals DIV-1.
- **RX path:**
  - rx passes through a 2-flop synchronizer; the RX FSM sees only the synchronized value.
  - IDLE: a synchronized low moves to START and clears the tick count.
  - START: after 8 rx_ticks (mid start bit), sample the line. Low moves to DATA. High is treated as a glitch and returns to IDLE with no flags.
  - DATA: sample every 16 rx_ticks; 8 bits, LSB first, shifted into a holding register.
  - PARITY (only with UART_PARITY_EN): one more sample after 16 rx_ticks.
  - STOP: sample after 16 rx_ticks, then return to IDLE. The outcome of that sample:
    - Low: pulse frame_err; the byte is discarded.
    - Parity mismatch: pulse parity_err; the byte is discarded.
    - Otherwise: the byte is delivered.
- **RX delivery:**
  - When rx_valid=0, load rx_data and set rx_valid.
  - When rx_valid=1 and rx_ack is not asserted this cycle: keep the old rx_data, drop the new byte, and set rx_overrun.
  - When rx_ack and a delivery land in the same cycle: load the new byte, keep rx_valid=1, and leave rx_overrun unchanged.
  - rx_ack alone clears rx_valid and rx_overrun.
  - rx_ack while rx_valid=0 is ignored.
- **TX path:**
  - FSM states: IDLE, START, DATA, (PARITY), STOP.
  - tx_start while tx_busy=0: latch tx_data and enter START.
  - tx_start while tx_busy=1: ignored, with no queueing.
  - Every bit lasts exactly 16*DIV clock cycles, counted by a dedicated cycle counter. The TX path does not use rx_tick.
  - Bit order on tx: start bit 0, then data LSB first, then the parity bit if enabled, then stop bit 1.

## Timing
- **TX start:** tx_busy and tx=0 both take effect on the cycle after the accepted tx_start.
- **TX frame length:** tx_busy stays high for 10*16*DIV cycles (11*16*DIV with parity), then drops. tx is already 1 during the stop bit.
- **Back-to-back TX:** tx_start may be accepted on the first cycle tx_busy=0. Frames therefore run back-to-back with no extra idle bit.
- **RX latency:**
  - The synchronizer adds 2 cycles of latency.
  - rx_valid rises the cycle after the stop-bit sample tick.
  - frame_err and parity_err pulse in that same cycle.
- **Sample-point accuracy:** the RX sample point jitters by up to DIV cycles, because the start edge is not aligned to the tick.

## Configuration
- **UART_PARITY_EN defined:**
  - Frames are 11 bits, with an even-parity bit (XOR of the data bits) after the data.
  - TX inserts the parity bit; RX checks it and pulses parity_err on a mismatch.
- **UART_PARITY_EN undefined:**
  - Frames are 10 bits (8N1).
  - The PARITY states are absent and parity_err is tied to 0.

## Test plan
All scenarios use CLK_FREQ=1_600_000 and BAUD=10_000, giving DIV=10 and a 160-cycle bit.
- **TX byte:** tx_start with 0xA5 → tx levels per bit are 0,1,0,1,0,0,1,0,1,1, each held 160 cycles. tx_busy is high for exactly 1600 cycles.
- **RX byte:** drive a 0x3C frame at 160 cycles/bit → rx_valid=1 and rx_data=0x3C; rx_ack then clears rx_valid the next cycle.
- **RX overrun:** send 0x11 then 0x22 with no ack → rx_data stays 0x11 and rx_overrun=1. An ack clears both flags.
- **Bad stop bit and glitch:**
  - Hold the stop bit low → frame_err pulses for 1 cycle and rx_valid stays 0.
  - A 40-cycle low glitch → no valid and no error.
- **Ack/delivery collision:** rx_ack asserted in the same cycle as the second byte's delivery → rx_data takes the new byte, rx_valid=1, rx_overrun=0.
- **Parity (UART_PARITY_EN):**
  - TX 0x07 → parity bit 1.
  - An RX frame with flipped parity → parity_err pulses and rx_valid stays 0.
  - Reset asserted mid-TX → tx=1 and tx_busy=0 immediately.
